// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 active-low keypad, debounces presses and
// releases, and emits a one-cycle command token per accepted key press.
module keypad_encoder #(
    parameter int unsigned IC_N     = 5,
    parameter logic [15:0] SCAN_DIV = 16'd1000,
    parameter logic [3:0]  DEB_N    = 4'd4
) (
    input  logic            Clock,
    input  logic            Reset,
    output logic [3:0]      col_n,
    input  logic [3:0]      row_n,
    output logic [IC_N-1:0] cmd,
    output logic            key_down
);

    localparam int unsigned DIV_W = 16;
    localparam int unsigned CNT_W = 4;

    // Shared command token encoding
    localparam logic [IC_N-1:0] IC_NONE = IC_N'(0);
    localparam logic [IC_N-1:0] IC_NUM0 = IC_N'(1);
    localparam logic [IC_N-1:0] IC_NUM1 = IC_N'(2);
    localparam logic [IC_N-1:0] IC_NUM2 = IC_N'(3);
    localparam logic [IC_N-1:0] IC_NUM3 = IC_N'(4);
    localparam logic [IC_N-1:0] IC_NUM4 = IC_N'(5);
    localparam logic [IC_N-1:0] IC_NUM5 = IC_N'(6);
    localparam logic [IC_N-1:0] IC_NUM6 = IC_N'(7);
    localparam logic [IC_N-1:0] IC_NUM7 = IC_N'(8);
    localparam logic [IC_N-1:0] IC_NUM8 = IC_N'(9);
    localparam logic [IC_N-1:0] IC_NUM9 = IC_N'(10);
    localparam logic [IC_N-1:0] IC_OPAD = IC_N'(11);
    localparam logic [IC_N-1:0] IC_OPSB = IC_N'(12);
    localparam logic [IC_N-1:0] IC_OPAN = IC_N'(13);
    localparam logic [IC_N-1:0] IC_OPOR = IC_N'(14);
    localparam logic [IC_N-1:0] IC_OPLS = IC_N'(15);
    localparam logic [IC_N-1:0] IC_CTOK = IC_N'(16);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         sync_a;
    logic [3:0]         sync_b;
    logic [DIV_W-1:0]   div;
    logic [1:0]         col;
    logic [1:0]         col_nxt;
    logic [1:0]         key_row;
    logic [1:0]         key_row_nxt;
    logic [CNT_W-1:0]   deb_cnt;
    logic [CNT_W-1:0]   deb_nxt;
    logic [CNT_W-1:0]   rel_cnt;
    logic [CNT_W-1:0]   rel_nxt;
    logic [IC_N-1:0]    cmd_nxt;
    logic               sample_c;
    logic               valid_c;
    logic [1:0]         row_idx_c;
    logic               match_c;
    logic [CNT_W-1:0]   deb_inc_c;
    logic [CNT_W-1:0]   rel_inc_c;

    function automatic logic [IC_N-1:0] key_token(input logic [1:0] r, input logic [1:0] c);
        logic [IC_N-1:0] t;
        case ({r, c})
            4'h0:    t = IC_NUM1;
            4'h1:    t = IC_NUM2;
            4'h2:    t = IC_NUM3;
            4'h3:    t = IC_OPAD;
            4'h4:    t = IC_NUM4;
            4'h5:    t = IC_NUM5;
            4'h6:    t = IC_NUM6;
            4'h7:    t = IC_OPSB;
            4'h8:    t = IC_NUM7;
            4'h9:    t = IC_NUM8;
            4'hA:    t = IC_NUM9;
            4'hB:    t = IC_OPAN;
            4'hC:    t = IC_CTOK;
            4'hD:    t = IC_NUM0;
            4'hE:    t = IC_OPLS;
            default: t = IC_OPOR;
        endcase
        return t;
    endfunction

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync_a <= 4'hF;
            sync_b <= 4'hF;
        end else begin
            sync_a <= row_n;
            sync_b <= sync_a;
        end
    end

    // Column-period divider; the last count of each period is the sample cycle
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            div <= '0;
        end else if (sample_c) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Row decode: a sample counts only with exactly one row pulled low
    always_comb begin
        sample_c  = (div == SCAN_DIV - DIV_W'(1));
        valid_c   = 1'b1;
        row_idx_c = 2'd0;
        case (~sync_b)
            4'b0001: row_idx_c = 2'd0;
            4'b0010: row_idx_c = 2'd1;
            4'b0100: row_idx_c = 2'd2;
            4'b1000: row_idx_c = 2'd3;
            default: valid_c   = 1'b0;
        endcase
        match_c   = valid_c && (row_idx_c == key_row);
        deb_inc_c = (deb_cnt == '1) ? deb_cnt : deb_cnt + CNT_W'(1);
        rel_inc_c = (rel_cnt == '1) ? rel_cnt : rel_cnt + CNT_W'(1);
    end

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, evaluated only on sample cycles
    always_comb begin
        state_nxt = state;
        if (sample_c) begin
            case (state)
                S_SCAN: begin
                    if (valid_c) state_nxt = S_DEBOUNCE;
                end
                S_DEBOUNCE: begin
                    if (!match_c)                state_nxt = S_SCAN;
                    else if (deb_inc_c == DEB_N) state_nxt = S_HELD;
                end
                S_HELD: begin
                    if (!match_c && rel_inc_c == DEB_N) state_nxt = S_SCAN;
                end
                default: state_nxt = S_SCAN;
            endcase
        end
    end

    // Datapath and output next values: column, recorded key, counters, token
    always_comb begin
        col_nxt     = col;
        key_row_nxt = key_row;
        deb_nxt     = deb_cnt;
        rel_nxt     = rel_cnt;
        cmd_nxt     = IC_NONE;
        if (sample_c) begin
            case (state)
                S_SCAN: begin
                    if (valid_c) begin
                        key_row_nxt = row_idx_c;
                        deb_nxt     = CNT_W'(1);
                        rel_nxt     = '0;
                    end else begin
                        col_nxt = col + 2'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (!match_c) begin
                        col_nxt = col + 2'd1;
                        deb_nxt = '0;
                        rel_nxt = '0;
                    end else if (deb_inc_c == DEB_N) begin
                        cmd_nxt = key_token(key_row, col);
                        deb_nxt = '0;
                        rel_nxt = '0;
                    end else begin
                        deb_nxt = deb_inc_c;
                    end
                end
                S_HELD: begin
                    if (match_c) begin
                        rel_nxt = '0;
                    end else if (rel_inc_c == DEB_N) begin
                        col_nxt = col + 2'd1;
                        deb_nxt = '0;
                        rel_nxt = '0;
                    end else begin
                        rel_nxt = rel_inc_c;
                    end
                end
                default: begin
                    deb_nxt = '0;
                    rel_nxt = '0;
                end
            endcase
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            col      <= 2'd0;
            key_row  <= 2'd0;
            deb_cnt  <= '0;
            rel_cnt  <= '0;
            cmd      <= IC_NONE;
            key_down <= 1'b0;
            col_n    <= 4'b1110;
        end else begin
            col      <= col_nxt;
            key_row  <= key_row_nxt;
            deb_cnt  <= deb_nxt;
            rel_cnt  <= rel_nxt;
            cmd      <= cmd_nxt;
            key_down <= (state_nxt == S_HELD);
            col_n    <= ~(4'b0001 << col_nxt);
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: a physical keypad model closes rows against the
// driven column; directed scenarios plus random press/release sequences.
module tb_keypad_encoder;

    localparam logic [4:0] IC_NONE = 5'd0;
    localparam logic [4:0] IC_NUM0 = 5'd1;
    localparam logic [4:0] IC_NUM1 = 5'd2;
    localparam logic [4:0] IC_NUM2 = 5'd3;
    localparam logic [4:0] IC_NUM3 = 5'd4;
    localparam logic [4:0] IC_NUM4 = 5'd5;
    localparam logic [4:0] IC_NUM5 = 5'd6;
    localparam logic [4:0] IC_NUM6 = 5'd7;
    localparam logic [4:0] IC_NUM7 = 5'd8;
    localparam logic [4:0] IC_NUM8 = 5'd9;
    localparam logic [4:0] IC_NUM9 = 5'd10;
    localparam logic [4:0] IC_OPAD = 5'd11;
    localparam logic [4:0] IC_OPSB = 5'd12;
    localparam logic [4:0] IC_OPAN = 5'd13;
    localparam logic [4:0] IC_OPOR = 5'd14;
    localparam logic [4:0] IC_OPLS = 5'd15;
    localparam logic [4:0] IC_CTOK = 5'd16;

    logic       Clock;
    logic       Reset;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [4:0] cmd;
    logic       key_down;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor)
    logic [4:0] tok_log[$];
    int n_wide = 0;
    int n_colbad = 0;
    int n_kd = 0;
    int col_hits[4] = '{0, 0, 0, 0};
    logic [4:0] prev_cmd = 5'd0;
    logic       prev_kd = 1'b0;

    keypad_encoder #(
        .IC_N(5),
        .SCAN_DIV(16'd4),
        .DEB_N(4'd2)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .col_n(col_n),
        .row_n(row_n),
        .cmd(cmd),
        .key_down(key_down)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Physical keypad: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    // Monitor: log tokens, flag tokens not coinciding with a fresh key_down rise
    always @(negedge Clock) begin
        if (cmd !== IC_NONE) begin
            tok_log.push_back(cmd);
            if (prev_cmd !== IC_NONE || key_down !== 1'b1 || prev_kd !== 1'b0) n_wide++;
        end
        if (key_down === 1'b1) n_kd++;
        case (col_n)
            4'b1110: col_hits[0]++;
            4'b1101: col_hits[1]++;
            4'b1011: col_hits[2]++;
            4'b0111: col_hits[3]++;
            default: n_colbad++;
        endcase
        prev_cmd = cmd;
        prev_kd  = key_down;
    end

    function automatic logic [15:0] kbit(input int r, input int c);
        return 16'(1) << (4*r + c);
    endfunction

    function automatic logic [4:0] tok_of(input int idx);
        case (idx)
            0: return IC_NUM1;   1: return IC_NUM2;   2: return IC_NUM3;   3: return IC_OPAD;
            4: return IC_NUM4;   5: return IC_NUM5;   6: return IC_NUM6;   7: return IC_OPSB;
            8: return IC_NUM7;   9: return IC_NUM8;  10: return IC_NUM9;  11: return IC_OPAN;
           12: return IC_CTOK;  13: return IC_NUM0;  14: return IC_OPLS;
           default: return IC_OPOR;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_kd(input logic v, input int maxc, input string tag);
        int n = 0;
        while (key_down !== v && n < maxc) begin
            @(negedge Clock);
            n++;
        end
        chk(tag, 32'(key_down), 32'(v));
    endtask

    initial begin
        int base;
        int cnt;
        int kd0;
        int hits0[4];
        logic [3:0] c0;
        logic [4:0] exp_q[$];

        Reset = 1'b1;
        keys  = '0;
        #3 Reset = 1'b0;
        repeat (2) @(negedge Clock);
        chk("rst_cmd", 32'(cmd), 32'(IC_NONE));
        chk("rst_kd", 32'(key_down), 32'd0);
        chk("rst_col", 32'(col_n), 32'h0E);

        // Key 7 held on column 0 from reset release
        keys = kbit(2, 0);
        @(negedge Clock);
        Reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clock);
            if (k == 7) begin
                chk("k7_c7_cmd", 32'(cmd), 32'(IC_NONE));
                chk("k7_c7_kd", 32'(key_down), 32'd0);
            end
            if (k == 8) begin
                chk("k7_c8_cmd", 32'(cmd), 32'(IC_NUM7));
                chk("k7_c8_kd", 32'(key_down), 32'd1);
            end
            if (k == 9) begin
                chk("k7_c9_cmd", 32'(cmd), 32'(IC_NONE));
                chk("k7_c9_kd", 32'(key_down), 32'd1);
            end
        end
        keys = '0;
        wait_kd(1'b0, 40, "k7_release");

        // Key 5 held 200 cycles then released
        repeat (10) @(negedge Clock);
        base = tok_log.size();
        keys = kbit(1, 1);
        repeat (200) @(negedge Clock);
        chk("k5_kd_held", 32'(key_down), 32'd1);
        chk("k5_ntok", 32'(tok_log.size() - base), 32'd1);
        chk("k5_tok", 32'(tok_log[base]), 32'(IC_NUM5));
        keys = '0;
        cnt = 0;
        while (key_down === 1'b1 && cnt < 30) begin
            @(negedge Clock);
            cnt++;
        end
        chk("k5_fall_min", 32'(cnt >= 7), 32'd1);
        chk("k5_fall_max", 32'(cnt <= 10), 32'd1);
        chk("k5_col_adv", 32'(col_n), 32'h0B);
        c0 = col_n;
        repeat (4) @(negedge Clock);
        chk("k5_rotate", 32'(col_n !== c0), 32'd1);

        // Bounce on key 1: one sample closed, one open, then stable
        Reset = 1'b0;
        @(negedge Clock);
        keys = kbit(0, 0);
        Reset = 1'b1;
        base = tok_log.size();
        for (int k = 1; k <= 29; k++) begin
            @(negedge Clock);
            if (k == 4) begin
                chk("bnc_first_cmd", 32'(cmd), 32'(IC_NONE));
                chk("bnc_first_kd", 32'(key_down), 32'd0);
                keys = '0;
            end
            if (k == 8) begin
                chk("bnc_abort_col", 32'(col_n), 32'h0D);
                chk("bnc_abort_kd", 32'(key_down), 32'd0);
                keys = kbit(0, 0);
            end
            if (k == 27) chk("bnc_c27_cmd", 32'(cmd), 32'(IC_NONE));
            if (k == 28) begin
                chk("bnc_c28_cmd", 32'(cmd), 32'(IC_NUM1));
                chk("bnc_c28_kd", 32'(key_down), 32'd1);
            end
        end
        chk("bnc_ntok", 32'(tok_log.size() - base), 32'd1);
        keys = '0;
        wait_kd(1'b0, 40, "bnc_release");

        // Two rows low together on column 3: never a valid key
        repeat (5) @(negedge Clock);
        base = tok_log.size();
        kd0 = n_kd;
        for (int i = 0; i < 4; i++) hits0[i] = col_hits[i];
        keys = kbit(0, 3) | kbit(1, 3);
        repeat (100) @(negedge Clock);
        chk("multi_ntok", 32'(tok_log.size() - base), 32'd0);
        chk("multi_kd", 32'(n_kd - kd0), 32'd0);
        chk("multi_cmd", 32'(cmd), 32'(IC_NONE));
        chk("multi_rotate", 32'((col_hits[0] > hits0[0]) && (col_hits[1] > hits0[1]) &&
                                (col_hits[2] > hits0[2]) && (col_hits[3] > hits0[3])), 32'd1);
        keys = '0;

        // Reset while held on CTOK, key stays pressed
        repeat (5) @(negedge Clock);
        base = tok_log.size();
        keys = kbit(3, 0);
        wait_kd(1'b1, 60, "ctok_held");
        repeat (10) @(negedge Clock);
        chk("ctok_first", 32'(tok_log[base]), 32'(IC_CTOK));
        Reset = 1'b0;
        #1;
        chk("ctok_rst_cmd", 32'(cmd), 32'(IC_NONE));
        chk("ctok_rst_kd", 32'(key_down), 32'd0);
        chk("ctok_rst_col", 32'(col_n), 32'h0E);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        base = tok_log.size();
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clock);
            if (k == 7) chk("ctok_c7_cmd", 32'(cmd), 32'(IC_NONE));
            if (k == 8) chk("ctok_c8_cmd", 32'(cmd), 32'(IC_CTOK));
        end
        chk("ctok_ntok", 32'(tok_log.size() - base), 32'd1);
        keys = '0;
        wait_kd(1'b0, 40, "ctok_release");

        // OPAD, release, then 9
        repeat (5) @(negedge Clock);
        base = tok_log.size();
        keys = kbit(0, 3);
        wait_kd(1'b1, 60, "seq_opad_down");
        keys = '0;
        wait_kd(1'b0, 40, "seq_opad_up");
        keys = kbit(2, 2);
        wait_kd(1'b1, 60, "seq_9_down");
        keys = '0;
        wait_kd(1'b0, 40, "seq_9_up");
        chk("seq_ntok", 32'(tok_log.size() - base), 32'd2);
        chk("seq_tok0", 32'(tok_log[base]), 32'(IC_OPAD));
        chk("seq_tok1", 32'(tok_log[base+1]), 32'(IC_NUM9));

        // Random presses: each long press yields exactly its mapped token
        repeat (5) @(negedge Clock);
        base = tok_log.size();
        for (int i = 0; i < 16; i++) begin
            int idx;
            idx = int'($urandom_range(0, 15));
            keys = 16'(1) << idx;
            exp_q.push_back(tok_of(idx));
            repeat ($urandom_range(60, 150)) @(negedge Clock);
            chk("rnd_held", 32'(key_down), 32'd1);
            keys = '0;
            repeat ($urandom_range(30, 80)) @(negedge Clock);
            chk("rnd_released", 32'(key_down), 32'd0);
        end
        chk("rnd_ntok", 32'(tok_log.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk("rnd_tok", 32'(tok_log[base+i]), 32'(exp_q[i]));

        chk("pulse_shape", 32'(n_wide), 32'd0);
        chk("col_onehot", 32'(n_colbad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
